// File: rtl/divexec_pkg.sv
// Shared definitions for the divide execution unit and its issue-queue users:
// default widths and the 3-bit FSM state encoding.
package divexec_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_TAG_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/divexec_divstep.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module divstep import divexec_pkg::*; #(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] dvsr_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // The shifted remainder needs one extra bit; the difference always fits back in DATA_W.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dvsr_i};
    assign q_o     = (shifted >= {1'b0, dvsr_i});
    assign rem_o   = q_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/divexec.sv
// Multi-cycle signed divider execution unit: accepts one instruction from the
// divide queue, computes the truncated quotient and holds it for the CDB.
module divexec import divexec_pkg::*; #(
    parameter int DATA_W = DIV_DATA_W,
    parameter int TAG_W  = DIV_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  issuediv_rdtag,
    input  logic [DATA_W-1:0] issuediv_rsdata,
    input  logic [DATA_W-1:0] issuediv_rtdata,
    input  logic              issuediv_ready,
    output logic              issuediv_done,
    output logic              cdbdiv_req,
    input  logic              cdbdiv_grant,
    output logic [TAG_W-1:0]  cdbdiv_tag,
    output logic [DATA_W-1:0] cdbdiv_data
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvsr_q;
    logic [DATA_W-1:0] data_q;
    logic              sign_q;
    logic              req_q;
    logic [DATA_W-1:0] rem_d;
    logic              qbit_d;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    // quo_q starts as |dividend| and fills with quotient bits as dividend bits shift out.
    divstep #(.DATA_W(DATA_W)) u_step (
        .rem_i  (rem_q),
        .dvsr_i (dvsr_q),
        .bit_i  (quo_q[DATA_W-1]),
        .rem_o  (rem_d),
        .q_o    (qbit_d)
    );

    assign issuediv_done = reset & (state_q == S_IDLE) & issuediv_ready;
    assign cdbdiv_req    = req_q;
    assign cdbdiv_tag    = tag_q;
    assign cdbdiv_data   = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            data_q  <= '0;
            sign_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issuediv_ready) begin
                        tag_q   <= issuediv_rdtag;
                        rs_q    <= issuediv_rsdata;
                        rt_q    <= issuediv_rtdata;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    quo_q  <= mag(rs_q);
                    dvsr_q <= mag(rt_q);
                    rem_q  <= '0;
                    sign_q <= rs_q[DATA_W-1] ^ rt_q[DATA_W-1];
                    // Divide-by-zero skips the iteration and reports all ones.
                    if (rt_q == '0) begin
                        data_q  <= '1;
                        req_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= CNT_W'(DATA_W - 1);
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[DATA_W-2:0], qbit_d};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    data_q  <= sign_q ? (~quo_q + 1'b1) : quo_q;
                    req_q   <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (cdbdiv_grant) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divexec.sv
// Directed testbench for divexec: a transaction-level reference model checks
// every cycle, and directed vectors pin latency and quotients to literal values.
module tb_divexec;

    localparam int DW = 32;
    localparam int TW = 6;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          ready  = 1'b0;
    logic          grant  = 1'b0;
    logic [TW-1:0] rdtag  = '0;
    logic [DW-1:0] rs_v   = '0;
    logic [DW-1:0] rt_v   = '0;
    logic          done;
    logic          req;
    logic [TW-1:0] ctag;
    logic [DW-1:0] cdata;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    bit            pending = 1'b0;
    bit            exp_req;
    int            acc_cyc = 0;
    int            m_lat   = 0;
    logic [TW-1:0] m_tag   = '0;
    logic [DW-1:0] m_q     = '0;

    divexec #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk             (clk),
        .reset           (reset),
        .issuediv_rdtag  (rdtag),
        .issuediv_rsdata (rs_v),
        .issuediv_rtdata (rt_v),
        .issuediv_ready  (ready),
        .issuediv_done   (done),
        .cdbdiv_req      (req),
        .cdbdiv_grant    (grant),
        .cdbdiv_tag      (ctag),
        .cdbdiv_data     (cdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Signed quotient truncated toward zero; 64-bit arithmetic makes MIN/-1 wrap naturally.
    function automatic logic [DW-1:0] model_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa;
        longint sb;
        if (b == '0) return '1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return DW'(sa / sb);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_done", done, 0);
            chk("rst_req", req, 0);
            chk("rst_tag", ctag, 0);
            chk("rst_data", cdata, 0);
            pending = 1'b0;
        end else if (!pending) begin
            chk("idle_done", done, ready);
            chk("idle_req", req, 0);
            if (ready) begin
                pending = 1'b1;
                acc_cyc = cyc;
                m_tag   = rdtag;
                m_q     = model_div(rs_v, rt_v);
                m_lat   = (rt_v == '0) ? 2 : 35;
            end
        end else begin
            chk("busy_done", done, 0);
            exp_req = (cyc >= acc_cyc + m_lat);
            chk("model_req", req, exp_req);
            if (exp_req) begin
                chk("model_tag", ctag, m_tag);
                chk("model_data", cdata, m_q);
                if (grant) pending = 1'b0;
            end
        end
    end

    task automatic issue(input logic [DW-1:0] rs, input logic [DW-1:0] rt, input logic [TW-1:0] tag,
                         input logic [DW-1:0] exp_q, input int exp_lat, input int gdelay,
                         input bit hold, input bit early, input bit rel);
        int t0;
        bit found;
        @(posedge clk); #1;
        if (rel) reset = 1'b1;
        rs_v = rs; rt_v = rt; rdtag = tag; ready = 1'b1; grant = early;
        t0 = cyc;
        @(negedge clk);
        chk("accept_done", done, 1);
        @(posedge clk); #1;
        ready = hold;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req) begin
                found = 1'b1;
                break;
            end
        end
        chk("req_seen", found, 1);
        chk("latency", cyc - t0, exp_lat);
        chk("lit_data", cdata, exp_q);
        chk("lit_tag", ctag, tag);
        if (!early) begin
            for (int k = 0; k < gdelay; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("hold_req", req, 1);
                chk("hold_data", cdata, exp_q);
                chk("hold_done", done, 0);
            end
            @(posedge clk); #1;
            grant = 1'b1;
            @(negedge clk);
            chk("grant_cycle_done", done, 0);
        end
        @(posedge clk); #1;
        grant = 1'b0;
    endtask

    task automatic drain(input logic [DW-1:0] exp_q);
        bit found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req) begin
                found = 1'b1;
                break;
            end
        end
        chk("drain_req", found, 1);
        chk("drain_data", cdata, exp_q);
        @(posedge clk); #1;
        grant = 1'b1;
        @(posedge clk); #1;
        grant = 1'b0;
    endtask

    initial begin
        bit seen;
        reset = 1'b0; ready = 1'b1; rs_v = 32'd100; rt_v = 32'd7; rdtag = 6'h05;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done_forced", done, 0);
        chk("reset_req", req, 0);

        // Reset released in the acceptance cycle itself.
        issue(32'd100,       32'd7,          6'h05, 32'd14,         35, 0, 1'b0, 1'b0, 1'b1);
        issue(32'hFFFFFF9C,  32'd7,          6'h01, 32'hFFFFFFF2,   35, 2, 1'b0, 1'b0, 1'b0);
        issue(32'h80000000,  32'hFFFFFFFF,   6'h02, 32'h80000000,   35, 0, 1'b0, 1'b0, 1'b0);
        issue(32'd5,         32'd0,          6'h3F, 32'hFFFFFFFF,    2, 1, 1'b0, 1'b0, 1'b0);
        issue(32'd7,         32'hFFFFFFFE,   6'h03, 32'hFFFFFFFD,   35, 0, 1'b0, 1'b0, 1'b0);
        issue(32'hFFFFFFF9,  32'hFFFFFFFE,   6'h04, 32'd3,          35, 0, 1'b0, 1'b0, 1'b0);
        issue(32'h7FFFFFFF,  32'd1,          6'h06, 32'h7FFFFFFF,   35, 0, 1'b0, 1'b0, 1'b0);
        issue(32'd3,         32'd100,        6'h07, 32'd0,          35, 0, 1'b0, 1'b0, 1'b0);
        issue(32'hFFFFFFFB,  32'd0,          6'h08, 32'hFFFFFFFF,    2, 0, 1'b0, 1'b0, 1'b0);
        // Grant held high through CALC must be ignored until DONE.
        issue(32'd81,        32'd9,          6'h09, 32'd9,          35, 0, 1'b0, 1'b1, 1'b0);

        // Grant withheld 10 cycles while ready stays high; re-accept right after grant.
        issue(32'd1000,      32'd10,         6'h0C, 32'd100,        35, 10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("reaccept_done", done, 1);
        @(posedge clk); #1;
        ready = 1'b0;
        drain(32'd100);

        // Reset in the middle of CALC abandons the operation.
        @(posedge clk); #1;
        rs_v = 32'd50; rt_v = 32'd7; rdtag = 6'h11; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req) seen = 1'b1;
        end
        chk("abandoned_req", seen, 0);
        issue(32'd9,         32'd3,          6'h2A, 32'd3,          35, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
